// File: rtl/pc_pkg.sv
// pc_pkg: shared PC increment and next-PC source encoding
package pc_pkg;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {SEQ, BRANCH, JUMP, RET} pc_src_e;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO that overwrites the oldest entry when full
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  assign top = mem[sp - PW'(1)];
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sp <= '0;
      count <= '0;
    end else if (push) begin
      mem[sp] <= push_data;
      sp <= sp + PW'(1);
      count <= (count == FULL) ? count : count + (PW+1)'(1);
    end else if (pop) begin
      sp <= sp - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter with branch/jump/return redirect and return-address stack
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pcWrite,
  input  logic                         branchTaken,
  input  logic [WIDTH-1:0]             branchTarget,
  input  logic                         jump,
  input  logic [WIDTH-1:0]             jumpTarget,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pcPlus4,
  output logic [$clog2(RAS_DEPTH):0]   rasCount,
  output logic                         rasEmpty,
  output logic                         rasFull,
  output logic                         rasErr
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  pc_src_e src;
  logic [WIDTH-1:0] ras_top, next_raw, next_pc;
  logic push, pop_req, pop;
  assign pcPlus4 = pc + WIDTH'(PC_INC);
  assign rasEmpty = rasCount == '0;
  assign rasFull = rasCount == CW'(RAS_DEPTH);
  assign push = pcWrite & jump & call & ~ret & ~branchTaken;
  assign pop_req = pcWrite & ret & ~branchTaken;
  assign pop = pop_req & ~rasEmpty;
  always_comb begin
    src = branchTaken ? BRANCH : ret ? (rasEmpty ? SEQ : RET) : jump ? JUMP : SEQ;
    next_raw = (src == BRANCH) ? branchTarget :
               (src == RET)    ? ras_top :
               (src == JUMP)   ? jumpTarget : pcPlus4;
    next_pc = {next_raw[WIDTH-1:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= {RESET_VEC[WIDTH-1:2], 2'b00};
      rasErr <= 1'b0;
    end else if (pcWrite) begin
      pc <= next_pc;
      rasErr <= rasErr | (pop_req & rasEmpty);
    end
  end
  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data(pcPlus4),
    .top(ras_top),
    .count(rasCount)
  );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a queue-based model
module tb_pc_gen;
  logic clk = 0, reset = 0, pcWrite = 0, branchTaken = 0, jump = 0, call = 0, ret = 0;
  logic [31:0] branchTarget = 0, jumpTarget = 0, pc, pcPlus4;
  logic [2:0] rasCount;
  logic rasEmpty, rasFull, rasErr;
  int errors = 0, checks = 0;
  bit chk_en = 0;
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit m_err;
  always #5 clk = ~clk;
  pc_gen dut (
    .clk(clk), .reset(reset), .pcWrite(pcWrite), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .jump(jump), .jumpTarget(jumpTarget),
    .call(call), .ret(ret), .pc(pc), .pcPlus4(pcPlus4), .rasCount(rasCount),
    .rasEmpty(rasEmpty), .rasFull(rasFull), .rasErr(rasErr)
  );
  always @(posedge clk) begin
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (!reset) begin
      m_pc = 32'h0;
      m_q.delete();
      m_err = 0;
    end else if (pcWrite) begin
      if (branchTaken) m_pc = branchTarget & ~32'h3;
      else if (ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin
          m_pc = p4;
          m_err = 1;
        end
      end else if (jump) begin
        if (call) begin
          m_q.push_back(p4);
          if (m_q.size() > 4) void'(m_q.pop_front());
        end
        m_pc = jumpTarget & ~32'h3;
      end else m_pc = p4;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", pc, m_pc);
      chk("model_pcPlus4", pcPlus4, m_pc + 32'd4);
      chk("model_rasCount", 32'(rasCount), 32'(m_q.size()));
      chk("model_rasEmpty", 32'(rasEmpty), 32'(m_q.size() == 0));
      chk("model_rasFull", 32'(rasFull), 32'(m_q.size() == 4));
      chk("model_rasErr", 32'(rasErr), 32'(m_err));
    end
  end
  task automatic cyc(input logic pw, input logic bt, input logic [31:0] bta, input logic j,
                     input logic [31:0] jta, input logic c, input logic r, input logic rs);
    pcWrite = pw; branchTaken = bt; branchTarget = bta; jump = j; jumpTarget = jta;
    call = c; ret = r; reset = rs;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic seq();
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic br(input logic [31:0] t);
    cyc(1, 1, t, 0, 0, 0, 0, 1);
  endtask
  task automatic jcall(input logic [31:0] t);
    cyc(1, 0, 0, 1, t, 1, 0, 1);
  endtask
  task automatic rt();
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h55, 1, 32'h77, 1, 1, 0);
    chk_en = 1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_empty", 32'(rasEmpty), 1);
    chk("reset_full", 32'(rasFull), 0);
    seq(); chk("seq_4", pc, 32'h4);
    seq(); chk("seq_8", pc, 32'h8);
    seq(); chk("seq_c", pc, 32'hC);
    br(32'h100); chk("br_100", pc, 32'h100);
    jcall(32'h400); chk("call_400", pc, 32'h400); chk("call_cnt1", 32'(rasCount), 1);
    seq(); chk("seq_404", pc, 32'h404);
    seq(); chk("seq_408", pc, 32'h408);
    rt(); chk("ret_104", pc, 32'h104); chk("ret_cnt0", 32'(rasCount), 0);
    br(32'h1000);
    jcall(32'h2000); jcall(32'h3000); jcall(32'h4000); jcall(32'h5000);
    chk("full_after4", 32'(rasFull), 1);
    jcall(32'h6000); chk("cnt_sat", 32'(rasCount), 4);
    rt(); chk("ret_5004", pc, 32'h5004);
    rt(); chk("ret_4004", pc, 32'h4004);
    rt(); chk("ret_3004", pc, 32'h3004);
    rt(); chk("ret_2004", pc, 32'h2004); chk("err_before", 32'(rasErr), 0);
    rt(); chk("underflow_pc", pc, 32'h2008); chk("underflow_err", 32'(rasErr), 1);
    repeat (3) begin
      cyc(0, 1, 32'h800, 0, 0, 0, 0, 1);
      chk("stall_pc", pc, 32'h2008);
    end
    br(32'h800); chk("unstall_800", pc, 32'h800);
    jcall(32'h900);
    cyc(1, 1, 32'h200, 1, 32'h700, 1, 1, 1);
    chk("bt_prio_pc", pc, 32'h200); chk("bt_prio_cnt", 32'(rasCount), 1);
    br(32'h203); chk("misalign", pc, 32'h200);
    cyc(1, 0, 0, 0, 0, 1, 0, 1); chk("call_nojump", pc, 32'h204);
    chk("call_nojump_cnt", 32'(rasCount), 1);
    chk("err_sticky", 32'(rasErr), 1);
    br(32'hFFFF_FFFC); chk("wrap_p4", pcPlus4, 32'h0);
    seq(); chk("wrap_pc", pc, 32'h0);
    jcall(32'h3000); chk("mid_cnt2", 32'(rasCount), 2);
    cyc(1, 0, 0, 1, 32'h5000, 1, 0, 0);
    chk("rst_mid_pc", pc, 32'h0); chk("rst_mid_cnt", 32'(rasCount), 0);
    chk("rst_mid_err", 32'(rasErr), 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom,
          $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1,
          $urandom_range(0, 4) == 0, $urandom_range(0, 99) != 0);
    end
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits (>= 8).
REQ-002 Parameter RESET_VEC, default 0, PC value after reset; 4-byte aligned.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 pcWrite  input  1  update enable; 0 holds all state (stall).
REQ-007 branchTaken  input  1  redirect to branchTarget.
REQ-008 branchTarget  input  WIDTH  branch destination.
REQ-009 jump  input  1  redirect to jumpTarget.
REQ-010 jumpTarget  input  WIDTH  jump destination.
REQ-011 call  input  1  qualifies jump as call: push return address.
REQ-012 ret  input  1  return: pop RAS top into PC.
REQ-013 pc  output  WIDTH  current PC, registered.
REQ-014 pcPlus4  output  WIDTH  pc + 4 modulo 2^WIDTH, combinational from pc.
REQ-015 rasCount  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-016 rasEmpty / rasFull  output  1 each  rasCount==0 / rasCount==RAS_DEPTH.
REQ-017 rasErr  output  1  sticky underflow flag.

Function
REQ-018 When pcWrite=0, pc, RAS contents, pointer, count and rasErr SHALL hold regardless of other inputs.
REQ-019 When pcWrite=1, the next-PC priority SHALL be branchTaken > ret > jump > sequential (pcPlus4).
REQ-020 Redirect latency SHALL be one cycle: the target appears on pc on the edge where the select is sampled.
REQ-021 Bits [1:0] of every target and of RESET_VEC SHALL be forced to 0; pc[1:0] is always 0.
REQ-022 Sequential increment SHALL wrap modulo 2^WIDTH (all-ones-minus-3 -> 0).
REQ-023 A push of pcPlus4 SHALL occur only when pcWrite=1, jump=1, call=1, ret=0, branchTaken=0.
REQ-024 A pop SHALL occur only when pcWrite=1, ret=1, branchTaken=0; call is then ignored.
REQ-025 call without jump SHALL be ignored (no push, sequential PC).
REQ-026 Push when full SHALL overwrite the oldest entry (circular); the top pointer wraps modulo RAS_DEPTH; rasCount saturates at RAS_DEPTH; not an error.
REQ-027 Pop when empty SHALL set next pc to pcPlus4, leave the pointer and count unchanged, and set rasErr.
REQ-028 Once set, rasErr SHALL stay 1 until reset.
REQ-029 branchTaken together with ret or call SHALL perform no push and no pop.

Reset
REQ-030 With reset=0 at a rising edge, pc SHALL load RESET_VEC, rasCount 0, the pointer 0, rasErr 0, and all RAS entries 0.
REQ-031 Reset SHALL override pcWrite and every other input, including mid-call or mid-return.
REQ-032 Outputs in the first cycle after reset release SHALL be pc=RESET_VEC, rasEmpty=1, rasFull=0.

Structure
REQ-033 Shared package pc_pkg SHALL hold the constant PC_INC=4 and the next-PC source enum: SEQ, BRANCH, JUMP, RET.
REQ-034 The stack SHALL be a sub-module ras_stack (circular LIFO; push, pop, top, count) instantiated once.
REQ-035 Next-PC selection SHALL be combinational; pc and the RAS state SHALL be the only registers.

Verification
REQ-036 Reset, then 3 cycles with pcWrite=1 and no controls -> pc 0x0, 0x4, 0x8, 0xC.
REQ-037 pc=0x100; jump+call to 0x400; 2 sequential cycles; ret -> pc 0x400, 0x404, 0x408, then 0x104; rasCount 1 -> 0.
REQ-038 With RAS_DEPTH=4, 5 nested calls, then 5 rets -> 4 correct return addresses (oldest lost), rasFull=1 after the 4th call; the 5th ret sets rasErr=1 and gives pc+4.
REQ-039 pcWrite=0 for 3 cycles while branchTaken=1 with target 0x800 -> pc unchanged; on pcWrite=1 -> pc=0x800.
REQ-040 Same cycle: branchTaken=1 to 0x200, ret=1, jump+call -> pc=0x200 and rasCount unchanged; a misaligned target 0x203 -> pc=0x200.
REQ-041 reset=0 asserted mid-call sequence with rasCount=2 -> next edge pc=RESET_VEC, rasCount=0, rasErr=0.
